// File: rtl/uart_tx_sched_if.sv
// Wishbone bundle between the UART transmit scheduler and
// the interconnect port that reaches the UART slave.
interface uart_tx_sched_if #(
   parameter int ADR_WIDTH = 32,
   parameter int DAT_WIDTH = 64
);
   logic                 cyc;
   logic                 stb;
   logic                 we;
   logic [ADR_WIDTH-1:0] adr;
   logic [DAT_WIDTH-1:0] dat_o;
   logic [DAT_WIDTH-1:0] dat_i;
   logic                 ack;
   logic                 err;

   modport master (
      output cyc, stb, we, adr, dat_o,
      input  dat_i, ack, err
   );

   modport slave (
      input  cyc, stb, we, adr, dat_o,
      output dat_i, ack, err
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between two byte requesters:
// round-robin pick, poll STAT until idle, then write DATA.
module uart_tx_sched #(
   parameter int          ADR_WIDTH  = 32,
   parameter int          DAT_WIDTH  = 64,
   parameter logic [31:0] UART_BASE  = 32'h0,
   parameter int          POLL_LIMIT = 1024
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req0_valid_i,
   input  logic [7:0] req0_data_i,
   output logic       req0_ready_o,
   input  logic       req1_valid_i,
   input  logic [7:0] req1_data_i,
   output logic       req1_ready_o,
   uart_tx_sched_if.master m,
   output logic       busy_o,
   output logic       err_o,
   output logic       timeout_o,
   input  logic       clr_i
);

   localparam int CW = $clog2(POLL_LIMIT + 1);
   localparam logic [CW-1:0] L_LIMIT = CW'(POLL_LIMIT);
   localparam logic [ADR_WIDTH-1:0] L_STAT_ADR =
      ADR_WIDTH'(UART_BASE + 32'h00);
   localparam logic [ADR_WIDTH-1:0] L_DATA_ADR =
      ADR_WIDTH'(UART_BASE + 32'h10);

   typedef enum logic [1:0] {
      S_IDLE,
      S_POLL,
      S_WRITE,
      S_GAP
   } state_t;

   state_t r_state;
   state_t w_state_nx;
   state_t r_after;
   state_t w_after_nx;

   logic                 r_rr_last;
   logic [7:0]           r_byte;
   logic [CW-1:0]        r_cnt;
   logic [CW-1:0]        w_cnt_nx;
   logic [CW-1:0]        w_cnt_inc;

   logic                 r_cyc;
   logic                 r_stb;
   logic                 r_we;
   logic [ADR_WIDTH-1:0] r_adr;
   logic [DAT_WIDTH-1:0] r_dat;
   logic                 w_cyc_nx;
   logic                 w_stb_nx;
   logic                 w_we_nx;
   logic [ADR_WIDTH-1:0] w_adr_nx;
   logic [DAT_WIDTH-1:0] w_dat_nx;

   logic                 w_issue_rd;
   logic                 w_issue_wr;
   logic                 w_drop;

   logic                 r_err;
   logic                 r_tmo;
   logic                 w_set_err;
   logic                 w_set_tmo;

   logic                 w_gnt0;
   logic                 w_gnt1;
   logic                 w_accept;
   logic                 w_unused;

   assign w_unused = ^m.dat_i[DAT_WIDTH-1:1];

   // Ready is gated by reset so it drops the instant reset asserts.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (rst_ni && (r_state == S_IDLE)) begin
         if (req0_valid_i && req1_valid_i) begin
            w_gnt0 = r_rr_last;
            w_gnt1 = !r_rr_last;
         end else begin
            w_gnt0 = req0_valid_i;
            w_gnt1 = req1_valid_i;
         end
      end
   end

   assign w_accept     = w_gnt0 | w_gnt1;
   assign req0_ready_o = w_gnt0;
   assign req1_ready_o = w_gnt1;

   assign w_cnt_inc = (r_cnt == L_LIMIT) ? r_cnt : r_cnt + CW'(1);

   always_comb begin
      w_state_nx = r_state;
      w_after_nx = r_after;
      w_cnt_nx   = r_cnt;
      w_issue_rd = 1'b0;
      w_issue_wr = 1'b0;
      w_drop     = 1'b0;
      w_set_err  = 1'b0;
      w_set_tmo  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nx = S_POLL;
               w_cnt_nx   = '0;
            end
         end
         S_POLL: begin
            if (!r_stb) begin
               w_issue_rd = 1'b1;
            end else if (m.err) begin
               w_drop     = 1'b1;
               w_set_err  = 1'b1;
               w_after_nx = S_IDLE;
               w_state_nx = S_GAP;
            end else if (m.ack) begin
               w_drop     = 1'b1;
               w_state_nx = S_GAP;
               if (!m.dat_i[0]) begin
                  w_after_nx = S_WRITE;
               end else begin
                  w_cnt_nx = w_cnt_inc;
                  if (w_cnt_inc == L_LIMIT) begin
                     w_set_tmo  = 1'b1;
                     w_after_nx = S_IDLE;
                  end else begin
                     w_after_nx = S_POLL;
                  end
               end
            end
         end
         S_WRITE: begin
            if (!r_stb) begin
               w_issue_wr = 1'b1;
            end else if (m.err) begin
               w_drop     = 1'b1;
               w_set_err  = 1'b1;
               w_after_nx = S_IDLE;
               w_state_nx = S_GAP;
            end else if (m.ack) begin
               w_drop     = 1'b1;
               w_after_nx = S_IDLE;
               w_state_nx = S_GAP;
            end
         end
         S_GAP: begin
            w_state_nx = r_after;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_cyc_nx = r_cyc;
      w_stb_nx = r_stb;
      w_we_nx  = r_we;
      w_adr_nx = r_adr;
      w_dat_nx = r_dat;
      unique case (1'b1)
         w_issue_rd: begin
            w_cyc_nx = 1'b1;
            w_stb_nx = 1'b1;
            w_we_nx  = 1'b0;
            w_adr_nx = L_STAT_ADR;
            w_dat_nx = '0;
         end
         w_issue_wr: begin
            w_cyc_nx = 1'b1;
            w_stb_nx = 1'b1;
            w_we_nx  = 1'b1;
            w_adr_nx = L_DATA_ADR;
            w_dat_nx = DAT_WIDTH'(r_byte);
         end
         w_drop: begin
            w_cyc_nx = 1'b0;
            w_stb_nx = 1'b0;
            w_we_nx  = 1'b0;
            w_adr_nx = '0;
            w_dat_nx = '0;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= S_IDLE;
         r_after   <= S_IDLE;
         r_rr_last <= 1'b1;
         r_byte    <= '0;
         r_cnt     <= '0;
         r_cyc     <= 1'b0;
         r_stb     <= 1'b0;
         r_we      <= 1'b0;
         r_adr     <= '0;
         r_dat     <= '0;
         r_err     <= 1'b0;
         r_tmo     <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_after <= w_after_nx;
         r_cnt   <= w_cnt_nx;
         r_cyc   <= w_cyc_nx;
         r_stb   <= w_stb_nx;
         r_we    <= w_we_nx;
         r_adr   <= w_adr_nx;
         r_dat   <= w_dat_nx;
         if (w_accept) begin
            r_byte    <= w_gnt1 ? req1_data_i : req0_data_i;
            r_rr_last <= w_gnt1;
         end
         // A set event in the same cycle as clr_i wins.
         r_err <= w_set_err | (r_err & ~clr_i);
         r_tmo <= w_set_tmo | (r_tmo & ~clr_i);
      end
   end

   assign m.cyc     = r_cyc;
   assign m.stb     = r_stb;
   assign m.we      = r_we;
   assign m.adr     = r_adr;
   assign m.dat_o   = r_dat;
   assign busy_o    = (r_state != S_IDLE);
   assign err_o     = r_err;
   assign timeout_o = r_tmo;

endmodule
